// File: rtl/cv32e40p_conv_tile_sched.sv
// Tile scheduler for the Winograd F(2x2,3x3) engine: walks the input map in
// 4x4 tiles (stride 2), loads each tile into the engine, starts it, and writes
// the 2x2 result block back to the (W-2)x(H-2) output map.
module cv32e40p_conv_tile_sched #(
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              eng_load_o,
    output logic [3:0]        eng_idx_o,
    output logic [31:0]       eng_data_o,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    input  logic [31:0]       eng_y0_i,
    input  logic [31:0]       eng_y1_i,
    input  logic [31:0]       eng_y2_i,
    input  logic [31:0]       eng_y3_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_ENG_START, S_ENG_WAIT, S_WR, S_NEXT, S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] in_base, out_base;
    logic [DIM_W-1:0]  width, height, tx, ty;
    logic [1:0]        row, col, wk;
    logic [31:0]       y_q [4];

    logic              cfg_legal, last_tx, last_ty;
    logic [DIM_W-1:0]  nx, ny;
    logic [1:0]        nr, nc, nk;
    logic [ADDR_W-1:0] in_stride, out_stride;

    // Byte address of pixel (oy+dy, ox+dx) in a word-per-pixel map of the given stride.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [ADDR_W-1:0] base,
        input logic [DIM_W-1:0]  oy,
        input logic [1:0]        dy,
        input logic [DIM_W-1:0]  ox,
        input logic [1:0]        dx,
        input logic [ADDR_W-1:0] stride
    );
        logic [ADDR_W-1:0] prow, pcol;
        prow = ADDR_W'(oy) + ADDR_W'(dy);
        pcol = ADDR_W'(ox) + ADDR_W'(dx);
        return base + ((prow * stride + pcol) << 2);
    endfunction

    // Next-position helpers for tile walk, in-tile read walk and write walk.
    always_comb begin
        cfg_legal  = ~cfg_width[0] & ~cfg_height[0] &
                     (cfg_width >= DIM_W'(4)) & (cfg_height >= DIM_W'(4));
        last_tx    = (tx == width - DIM_W'(4));
        last_ty    = (ty == height - DIM_W'(4));
        nx         = last_tx ? '0 : tx + DIM_W'(2);
        ny         = last_tx ? ty + DIM_W'(2) : ty;
        nc         = col + 2'd1;
        nr         = (col == 2'd3) ? row + 2'd1 : row;
        nk         = wk + 2'd1;
        in_stride  = ADDR_W'(width);
        out_stride = ADDR_W'(width - DIM_W'(2));
    end

    // Tile words pass straight from the read-data bus into the engine.
    assign eng_load_o = (state == S_RD_WAIT) && mem_rvalid_i;
    assign eng_idx_o  = eng_load_o ? {row, col} : '0;
    assign eng_data_o = eng_load_o ? mem_rdata_i : '0;

    // Scheduler FSM with registered memory/engine/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_base     <= '0;
            out_base    <= '0;
            width       <= '0;
            height      <= '0;
            tx          <= '0;
            ty          <= '0;
            row         <= '0;
            col         <= '0;
            wk          <= '0;
            for (int unsigned i = 0; i < 4; i++) y_q[i] <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            eng_start_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        in_base  <= cfg_in_base;
                        out_base <= cfg_out_base;
                        width    <= cfg_width;
                        height   <= cfg_height;
                        tx       <= '0;
                        ty       <= '0;
                        row      <= '0;
                        col      <= '0;
                        wk       <= '0;
                        busy_o   <= 1'b1;
                        if (cfg_legal) begin
                            err_o      <= 1'b0;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= cfg_in_base;
                            state      <= S_RD_REQ;
                        end else begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        row <= nr;
                        col <= nc;
                        if (row == 2'd3 && col == 2'd3) begin
                            eng_start_o <= 1'b1;
                            state       <= S_ENG_START;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= pix_addr(in_base, ty, nr, tx, nc, in_stride);
                            state      <= S_RD_REQ;
                        end
                    end
                end
                S_ENG_START: begin
                    eng_start_o <= 1'b0;
                    state       <= S_ENG_WAIT;
                end
                S_ENG_WAIT: begin
                    if (eng_done_i) begin
                        y_q[0]      <= eng_y0_i;
                        y_q[1]      <= eng_y1_i;
                        y_q[2]      <= eng_y2_i;
                        y_q[3]      <= eng_y3_i;
                        wk          <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= pix_addr(out_base, ty, 2'd0, tx, 2'd0, out_stride);
                        mem_wdata_o <= eng_y0_i;
                        state       <= S_WR;
                    end
                end
                S_WR: begin
                    if (mem_gnt_i) begin
                        if (wk == 2'd3) begin
                            mem_req_o   <= 1'b0;
                            mem_we_o    <= 1'b0;
                            mem_wdata_o <= '0;
                            state       <= S_NEXT;
                        end else begin
                            wk          <= nk;
                            mem_addr_o  <= pix_addr(out_base, ty, {1'b0, nk[1]},
                                                    tx, {1'b0, nk[0]}, out_stride);
                            mem_wdata_o <= y_q[nk];
                        end
                    end
                end
                S_NEXT: begin
                    if (last_tx && last_ty) begin
                        done_o <= 1'b1;
                        state  <= S_FIN;
                    end else begin
                        tx         <= nx;
                        ty         <= ny;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= pix_addr(in_base, ny, 2'd0, nx, 2'd0, in_stride);
                        state      <= S_RD_REQ;
                    end
                end
                S_FIN: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_conv_tile_sched.sv
// Scoreboard bench: expected memory transactions and engine loads are queued per
// layer; responder/monitor processes pop and compare as the DUT issues them.
module tb_cv32e40p_conv_tile_sched;

    localparam int DIM_W  = 10;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_in_base, cfg_out_base;
    logic [DIM_W-1:0]  cfg_width, cfg_height;
    logic              busy_o, done_o, err_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              eng_load_o;
    logic [3:0]        eng_idx_o;
    logic [31:0]       eng_data_o;
    logic              eng_start_o, eng_done_i;
    logic [31:0]       eng_y0_i, eng_y1_i, eng_y2_i, eng_y3_i;

    cv32e40p_conv_tile_sched #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .eng_load_o(eng_load_o), .eng_idx_o(eng_idx_o),
        .eng_data_o(eng_data_o), .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
        .eng_y0_i(eng_y0_i), .eng_y1_i(eng_y1_i), .eng_y2_i(eng_y2_i), .eng_y3_i(eng_y3_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; } ld_t;

    txn_t exp_mem[$];
    ld_t  exp_ld[$];

    int n_checks = 0;
    int n_pass   = 0;
    int max_stall = 0;
    int done_cnt = 0;
    int ld_cnt   = 0;
    int eng_tile = 0;
    int start_cnt = 0;
    bit req_ever = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] y_val(input int tile, input int k);
        return 32'hE000_0000 + 32'(tile * 16 + k);
    endfunction

    // Queue the 16 reads and engine loads of the tile at (tx,ty), row-major.
    task automatic push_tile_reads(input logic [31:0] base, input int w, input int tx, input int ty);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                logic [31:0] a;
                a = base + 32'(4 * ((ty + r) * w + tx + c));
                exp_mem.push_back('{1'b0, a, 32'h0});
                exp_ld.push_back('{4'(r * 4 + c), rd_data(a)});
            end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_mem.push_back('{1'b1, a, d});
    endtask

    // Single 4x4 layer at in 0x100 / out 0x200.
    task automatic push_layer_4x4();
        push_tile_reads(32'h100, 4, 0, 0);
        push_write(32'h200, y_val(0, 0));
        push_write(32'h204, y_val(0, 1));
        push_write(32'h208, y_val(0, 2));
        push_write(32'h20C, y_val(0, 3));
    endtask

    // Memory responder and transaction monitor: random grant stalls, rvalid the
    // cycle after a read grant, and scoreboard compare at each grant.
    logic        lat_we = 1'b1;
    logic [31:0] lat_addr = '0;
    int          wait_cnt = -1;
    bit          hold_valid = 0;
    txn_t        hold;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            wait_cnt = -1; hold_valid = 0; lat_we = 1'b1;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (mem_gnt_i && !lat_we) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rd_data(lat_addr);
            end
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
                req_ever = 1;
                if (hold_valid) begin
                    check("stall_we", 64'(mem_we_o), 64'(hold.we));
                    check("stall_addr", 64'(mem_addr_o), 64'(hold.addr));
                    check("stall_wdata", 64'(mem_wdata_o), 64'(hold.wdata));
                end
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(max_stall));
                if (wait_cnt == 0) begin
                    mem_gnt_i = 1'b1;
                    wait_cnt = -1;
                    hold_valid = 0;
                    lat_we = mem_we_o;
                    lat_addr = mem_addr_o;
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected_txn", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        txn_t t;
                        t = exp_mem.pop_front();
                        check("mem_we", 64'(mem_we_o), 64'(t.we));
                        check("mem_addr", 64'(mem_addr_o), 64'(t.addr));
                        if (t.we) check("mem_wdata", 64'(mem_wdata_o), 64'(t.wdata));
                    end
                end else begin
                    wait_cnt--;
                    hold_valid = 1;
                    hold = '{mem_we_o, mem_addr_o, mem_wdata_o};
                end
            end else begin
                hold_valid = 0;
            end
        end
    end

    // Engine load monitor.
    always @(negedge clk) begin
        #1;
        if (rst_n && eng_load_o) begin
            ld_cnt++;
            if (exp_ld.size() == 0) begin
                check("eng_load_unexpected", 64'(eng_idx_o), 64'hFF);
            end else begin
                ld_t l;
                l = exp_ld.pop_front();
                check("eng_idx", 64'(eng_idx_o), 64'(l.idx));
                check("eng_data", 64'(eng_data_o), 64'(l.data));
            end
        end
    end

    // Engine model: results 3 cycles after start, tagged with a per-layer tile number.
    int eng_cd = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_cd = 0; eng_done_i = 1'b0;
            eng_y0_i = '0; eng_y1_i = '0; eng_y2_i = '0; eng_y3_i = '0;
        end else begin
            eng_done_i = 1'b0;
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) eng_done_i = 1'b1;
            end
            if (eng_start_o) begin
                start_cnt++;
                eng_y0_i = y_val(eng_tile, 0);
                eng_y1_i = y_val(eng_tile, 1);
                eng_y2_i = y_val(eng_tile, 2);
                eng_y3_i = y_val(eng_tile, 3);
                eng_tile++;
                eng_cd = 3;
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic start_layer(input int w, input int h, input logic [31:0] ib, input logic [31:0] ob);
        @(negedge clk);
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
        cfg_in_base = ib; cfg_out_base = ob;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #2;
        check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy_after"}, 64'(busy_o), 64'd0);
        check({name, "_mem_drained"}, 64'(exp_mem.size()), 64'd0);
        check({name, "_ld_drained"}, 64'(exp_ld.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, 64'(busy_o), 0);
        check({name, "_done"}, 64'(done_o), 0);
        check({name, "_err"}, 64'(err_o), 0);
        check({name, "_req"}, 64'(mem_req_o), 0);
        check({name, "_we"}, 64'(mem_we_o), 0);
        check({name, "_addr"}, 64'(mem_addr_o), 0);
        check({name, "_wdata"}, 64'(mem_wdata_o), 0);
        check({name, "_load"}, 64'(eng_load_o), 0);
        check({name, "_idx"}, 64'(eng_idx_o), 0);
        check({name, "_edata"}, 64'(eng_data_o), 0);
        check({name, "_estart"}, 64'(eng_start_o), 0);
    endtask

    initial begin
        int d0, s0, t;
        rst_n = 1'b0; cfg_start = 1'b0;
        cfg_in_base = '0; cfg_out_base = '0; cfg_width = '0; cfg_height = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        eng_done_i = 1'b0; eng_y0_i = '0; eng_y1_i = '0; eng_y2_i = '0; eng_y3_i = '0;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // 1: single 4x4 tile, no stalls
        max_stall = 0; eng_tile = 0; push_layer_4x4();
        d0 = done_cnt;
        start_layer(4, 4, 32'h100, 32'h200);
        #1 check("t1_busy_after_start", 64'(busy_o), 1);
        wait_done("t1", d0);

        // 2: 6x4 map, two tiles, output width 4
        eng_tile = 0;
        push_tile_reads(32'h100, 6, 0, 0);
        push_write(32'h200, y_val(0, 0)); push_write(32'h204, y_val(0, 1));
        push_write(32'h210, y_val(0, 2)); push_write(32'h214, y_val(0, 3));
        push_tile_reads(32'h100, 6, 2, 0);
        push_write(32'h208, y_val(1, 0)); push_write(32'h20C, y_val(1, 1));
        push_write(32'h218, y_val(1, 2)); push_write(32'h21C, y_val(1, 3));
        d0 = done_cnt; s0 = start_cnt;
        start_layer(6, 4, 32'h100, 32'h200);
        wait_done("t2", d0);
        check("t2_tiles", 64'(start_cnt - s0), 2);

        // 3: random grant stalls, same image as 1
        max_stall = 5; eng_tile = 0; push_layer_4x4();
        d0 = done_cnt;
        start_layer(4, 4, 32'h100, 32'h200);
        wait_done("t3", d0);
        max_stall = 0;

        // 4: illegal dims -> error, done next cycle, no traffic
        req_ever = 0;
        start_layer(5, 4, 32'h100, 32'h200);
        #1;
        check("t4_w5_done", 64'(done_o), 1);
        check("t4_w5_err", 64'(err_o), 1);
        check("t4_w5_busy", 64'(busy_o), 1);
        @(negedge clk) #1;
        check("t4_w5_done_drop", 64'(done_o), 0);
        check("t4_w5_err_sticky", 64'(err_o), 1);
        start_layer(4, 2, 32'h100, 32'h200);
        #1 check("t4_h2_err", 64'(err_o), 1);
        check("t4_h2_done", 64'(done_o), 1);
        repeat (3) @(negedge clk);
        check("t4_no_req", 64'(req_ever), 0);

        // 5: start pulse during ENG_WAIT ignored; legal start clears err
        eng_tile = 0; push_layer_4x4();
        d0 = done_cnt; s0 = start_cnt;
        start_layer(4, 4, 32'h100, 32'h200);
        #1 check("t5_err_cleared", 64'(err_o), 0);
        t = 0;
        while (!eng_start_o && t < 2000) begin @(negedge clk); t++; end
        check("t5_reached_eng", 64'(eng_start_o), 1);
        @(negedge clk);
        cfg_width = 10'd6; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done("t5", d0);
        check("t5_tiles", 64'(start_cnt - s0), 1);

        // 6: reset during RD_WAIT of tile 2, then fresh run from tile (0,0)
        eng_tile = 0;
        push_tile_reads(32'h100, 6, 0, 0);
        push_write(32'h200, y_val(0, 0)); push_write(32'h204, y_val(0, 1));
        push_write(32'h210, y_val(0, 2)); push_write(32'h214, y_val(0, 3));
        push_tile_reads(32'h100, 6, 2, 0);
        ld_cnt = 0;
        start_layer(6, 4, 32'h100, 32'h200);
        t = 0;
        while (ld_cnt < 19 && t < 2000) begin @(negedge clk); t++; end
        t = 0;
        while (!(busy_o && !mem_req_o && !eng_start_o) && t < 100) begin @(negedge clk); t++; end
        check("t6_in_rd_wait", 64'(busy_o && !mem_req_o), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6_reset");
        exp_mem.delete(); exp_ld.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        eng_tile = 0; push_layer_4x4();
        d0 = done_cnt;
        start_layer(4, 4, 32'h100, 32'h200);
        wait_done("t6_rerun", d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
